// File: rtl/branch_predictor_if.sv
// Fetch-lookup and EX-resolve bundle for the branch predictor.
// slave: predictor side; master: core side driving PC and resolutions.
interface branch_predictor_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] lookup_pc;
  logic              predict_taken;
  logic [DATA_W-1:0] predict_pc;
  logic              upd_valid;
  logic [DATA_W-1:0] upd_pc;
  logic              upd_taken;
  logic [DATA_W-1:0] upd_target;
  logic              upd_pred_taken;
  logic [DATA_W-1:0] upd_pred_pc;
  logic              mispredict;
  logic [DATA_W-1:0] redirect_pc;
  logic [31:0]       stat_branches;
  logic [31:0]       stat_mispredicts;

  modport slave (
    input  lookup_pc,
    input  upd_valid,
    input  upd_pc,
    input  upd_taken,
    input  upd_target,
    input  upd_pred_taken,
    input  upd_pred_pc,
    output predict_taken,
    output predict_pc,
    output mispredict,
    output redirect_pc,
    output stat_branches,
    output stat_mispredicts
  );

  modport master (
    output lookup_pc,
    output upd_valid,
    output upd_pc,
    output upd_taken,
    output upd_target,
    output upd_pred_taken,
    output upd_pred_pc,
    input  predict_taken,
    input  predict_pc,
    input  mispredict,
    input  redirect_pc,
    input  stat_branches,
    input  stat_mispredicts
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters and stats.
// Ports: clk, rst (async high), bus (branch_predictor_if.slave).
module branch_predictor #(
  parameter int DATA_W  = 32,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2,
  parameter int MODE    = 1
) (
  input  logic                clk,
  input  logic                rst,
  branch_predictor_if.slave   bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic BTB_ON = (MODE == 1);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_ONE << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_ONE;

  logic              vld_q [ENTRIES];
  logic [TAG_W-1:0]  tag_q [ENTRIES];
  logic [DATA_W-1:0] tgt_q [ENTRIES];
  logic [CNT_W-1:0]  cnt_q [ENTRIES];

  logic [31:0] stat_br_q;
  logic [31:0] stat_mp_q;

  logic [IDX_W-1:0] l_idx;
  logic [TAG_W-1:0] l_tag;
  logic             l_hit;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic [CNT_W-1:0] cnt_nx;
  logic             mp;

  // Lookup side
  assign l_idx = bus.lookup_pc[IDX_W+1:2];
  assign l_tag = bus.lookup_pc[IDX_W+1+TAG_W:IDX_W+2];
  assign l_hit = vld_q[l_idx] && (tag_q[l_idx] == l_tag);

  assign bus.predict_taken = !rst && BTB_ON && l_hit
                           && cnt_q[l_idx][CNT_W-1];
  assign bus.predict_pc = bus.predict_taken
                        ? tgt_q[l_idx]
                        : bus.lookup_pc + DATA_W'(4);

  // Resolution side
  assign u_idx = bus.upd_pc[IDX_W+1:2];
  assign u_tag = bus.upd_pc[IDX_W+1+TAG_W:IDX_W+2];
  assign u_hit = vld_q[u_idx] && (tag_q[u_idx] == u_tag);

  // Wrong direction, or taken with a wrong predicted target
  assign mp = !rst && bus.upd_valid
            && ((bus.upd_pred_taken != bus.upd_taken)
             || (bus.upd_taken
              && (bus.upd_pred_pc != bus.upd_target)));

  assign bus.mispredict  = mp;
  assign bus.redirect_pc = bus.upd_taken
                         ? bus.upd_target
                         : bus.upd_pc + DATA_W'(4);

  assign bus.stat_branches    = stat_br_q;
  assign bus.stat_mispredicts = stat_mp_q;

  // Saturating counter step for a hit
  always_comb begin
    cnt_nx = cnt_q[u_idx];
    if (bus.upd_taken) begin
      if (cnt_q[u_idx] != CNT_MAX)
        cnt_nx = cnt_q[u_idx] + CNT_ONE;
    end else begin
      if (cnt_q[u_idx] != '0)
        cnt_nx = cnt_q[u_idx] - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        vld_q[i] <= 1'b0;
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        cnt_q[i] <= CNT_WNT;
      end
    end else if (BTB_ON && bus.upd_valid) begin
      if (u_hit) begin
        cnt_q[u_idx] <= cnt_nx;
        if (bus.upd_taken)
          tgt_q[u_idx] <= bus.upd_target;
      end else if (bus.upd_taken) begin
        vld_q[u_idx] <= 1'b1;
        tag_q[u_idx] <= u_tag;
        tgt_q[u_idx] <= bus.upd_target;
        cnt_q[u_idx] <= CNT_WT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (bus.upd_valid)
        stat_br_q <= stat_br_q + 32'd1;
      if (mp)
        stat_mp_q <= stat_mp_q + 32'd1;
    end
  end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch target buffer with saturating direction counters. It replaces the fixed prediction path between the PC/IF stage and EX-stage branch resolution in the pipelined core. IF sees a combinational prediction for the fetch PC. EX reports each resolved branch back to the block, which updates the table, raises a redirect on a misprediction, and keeps prediction statistics.

## Interface
- DATA_W, 32, PC and target width
- ENTRIES, 64, table depth; power of two, ≥2; IDX_W = log2(ENTRIES)
- TAG_W, 8, tag bits taken from pc[IDX_W+1+TAG_W : IDX_W+2]
- CNT_W, 2, direction counter width, ≥1
- MODE, 1, 0 = static not-taken (table never written), 1 = bimodal BTB

Ports:
- clk  in  1  core clock (cpuclk domain)
- rst  in  1  asynchronous, active-high reset
- lookup_pc  in  DATA_W  current fetch PC
- predict_taken  out  1  prediction for lookup_pc
- predict_pc  out  DATA_W  predicted next PC
- upd_valid  in  1  a resolved branch is presented this cycle
- upd_pc  in  DATA_W  PC of the resolved branch
- upd_taken  in  1  actual direction
- upd_target  in  DATA_W  actual taken target
- upd_pred_taken  in  1  prediction that travelled with the branch
- upd_pred_pc  in  DATA_W  predicted next PC that travelled with it
- mispredict  out  1  flush request
- redirect_pc  out  DATA_W  correct next PC
- stat_branches  out  32  resolved-branch count
- stat_mispredicts  out  32  misprediction count

## Operation
- Index: pc[IDX_W+1:2]. Tag: the TAG_W bits directly above the index.
- Each entry holds valid, tag, target and a CNT_W counter.
- Hit: valid && tag == lookup tag.
- Lookup is combinational from registered state:
  - predict_taken = (MODE==1) && hit && counter[CNT_W-1].
  - predict_pc = predict_taken ? target : lookup_pc+4, modulo 2^DATA_W.
- Misprediction: mispredict = upd_valid && ((upd_pred_taken != upd_taken) || (upd_taken && upd_pred_pc != upd_target)).
- redirect_pc = upd_taken ? upd_target : upd_pc+4. It is driven continuously; it is meaningful only while mispredict=1.
- Table update on a clk edge with upd_valid=1 and MODE==1:
  - Hit: the counter saturates up on taken and down on not-taken, never wrapping. On taken, target ← upd_target.
  - Miss and taken: allocate (overwrite) the entry with valid=1, the new tag, target=upd_target, counter=2^(CNT_W-1) (weakly taken).
  - Miss and not-taken: no change.
- Statistics, all modes:
  - stat_branches increments on every upd_valid.
  - stat_mispredicts increments when mispredict=1.
  - Both wrap from 0xFFFFFFFF to 0.
- CNT_W=1: the counter is the direction bit itself. Allocation value is 1.

## Timing
- Lookup path: zero latency, combinational. No pipeline registers inside the block.
- Update visibility: one cycle. A lookup in the same cycle as an update to the same index returns the pre-update entry; the next cycle reflects the update.
- mispredict and redirect_pc: combinational in the upd_valid cycle. The core flushes IF/ID and ID/EX in that cycle. The block does not hold the flush.
- Simultaneous lookup and update to different indices are independent.
- Stall handling is the core's job: the core gates upd_valid low during dcache/icache stalls so each branch is reported exactly once. upd_valid=1 for N cycles counts as N updates.
- Reset (asynchronous, takes effect mid-cycle):
  - all valid bits ← 0; counters ← 2^(CNT_W-1)-1 (weakly not-taken); targets and tags ← 0; stats ← 0.
  - While rst=1: predict_taken=0, predict_pc=lookup_pc+4, mispredict=0, and no state updates occur.
  - Deassertion is synchronous to the core's reset synchroniser. The first update is accepted on the first edge with rst=0.

## Test plan
All scenarios use the defaults (index = pc[7:2], tag = pc[15:8]).
- Reset check: rst pulse, then lookup_pc=0x1c090000 → predict_taken=0, predict_pc=0x1c090004, stat_branches=0, stat_mispredicts=0.
- Allocation: upd_pc=0x1c090010, taken, target 0x1c090100, upd_pred_taken=0, upd_pred_pc=0x1c090014 → same cycle mispredict=1, redirect_pc=0x1c090100. Next cycle, lookup 0x1c090010 → taken, predict_pc 0x1c090100. stats = 1/1.
- Saturation: from the allocation above, three not-taken updates with correct upd_pred fields. Counter goes 2→1→0→0. After the first update the lookup predicts not-taken. mispredict is asserted only on updates whose upd_pred_taken=1. Four taken updates then saturate the counter at 3.
- Aliasing: with 0x1c090010 allocated, lookup 0x1c090410 (same index, tag 0x04 vs 0x00) → miss, not-taken, predict_pc 0x1c090414. A taken update at 0x1c090410 then evicts the entry, and 0x1c090010 misses.
- Same-cycle hazard plus wrong target: in one cycle, look up and update 0x1c090010 (hit, taken, new target 0x1c090200, upd_pred_pc=0x1c090100). The lookup returns 0x1c090100; mispredict=1 with redirect 0x1c090200. The next cycle's lookup returns 0x1c090200.
- MODE=0 and reset mid-update:
  - With MODE=0, any update sequence never produces predict_taken=1, while stats still count.
  - Assert rst while upd_valid=1 → outputs return to their reset values immediately and stats=0.
  - Preload stat_branches near 0xFFFFFFFF, then add two updates → count wraps to 0x00000001.
